// File: rtl/stoch_signed_col2im.sv
// Folds a stream of signed stochastic column rows (dual-rail p/m bits) back
// into per-pixel signed overlap counts; holds each finished frame until taken.
module stoch_signed_col2im #(
    parameter int IM_HEIGHT = 4,
    parameter int IM_WIDTH  = 4,
    parameter int CHANNELS  = 2,
    parameter int KERNEL_H  = 3,
    parameter int KERNEL_W  = 3,
    parameter int PAD_H     = 1,
    parameter int PAD_W     = 1,
    parameter int STRIDE_H  = 1,
    parameter int STRIDE_W  = 1,
    localparam int OUT_H      = (IM_HEIGHT + 2*PAD_H - KERNEL_H) / STRIDE_H + 1,
    localparam int OUT_W      = (IM_WIDTH  + 2*PAD_W - KERNEL_W) / STRIDE_W + 1,
    localparam int COL_HEIGHT = OUT_H * OUT_W,
    localparam int COL_WIDTH  = KERNEL_H * KERNEL_W * CHANNELS,
    localparam int MAX_OVL    = ((KERNEL_H + STRIDE_H - 1) / STRIDE_H) *
                                ((KERNEL_W + STRIDE_W - 1) / STRIDE_W),
    localparam int CNT_W      = $clog2(MAX_OVL + 1) + 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COL_WIDTH-1:0] col_p,
    input  logic [COL_WIDTH-1:0] col_m,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0][CNT_W-1:0] im_cnt
);

    localparam int TAPS  = KERNEL_H * KERNEL_W;
    localparam int NPIX  = IM_HEIGHT * IM_WIDTH * CHANNELS;
    localparam int OY_W  = $clog2(OUT_H + 1);
    localparam int OX_W  = $clog2(OUT_W + 1);
    localparam int ROW_W = $clog2(COL_HEIGHT + 1);

    localparam logic [OX_W-1:0]  OX_LAST  = OX_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(COL_HEIGHT - 1);

    typedef enum logic {ACCUM, OUTPUT} state_t;

    state_t           state_reg;
    logic [OY_W-1:0]  oy_reg;
    logic [OX_W-1:0]  ox_reg;
    logic [ROW_W-1:0] row_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic accept;
    logic release_frame;

    assign accept        = in_valid && in_ready_reg;
    assign release_frame = out_valid_reg && out_ready;
    assign in_ready      = in_ready_reg;
    assign out_valid     = out_valid_reg;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg     <= ACCUM;
            oy_reg        <= '0;
            ox_reg        <= '0;
            row_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        row_reg <= row_reg + 1'b1;
                        if (ox_reg == OX_LAST) begin
                            ox_reg <= '0;
                            oy_reg <= oy_reg + 1'b1;
                        end else begin
                            ox_reg <= ox_reg + 1'b1;
                        end
                        if (row_reg == ROW_LAST) begin
                            state_reg     <= OUTPUT;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (release_frame) begin
                        state_reg     <= ACCUM;
                        oy_reg        <= '0;
                        ox_reg        <= '0;
                        row_reg       <= '0;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    // One counter per (y, x, c). Each kernel tap that can ever land on this
    // pixel is resolved at elaboration into the single (oy, ox) that reaches it.
    generate
        for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
            localparam int Y = gi / (IM_WIDTH * CHANNELS);
            localparam int X = (gi / CHANNELS) % IM_WIDTH;
            localparam int C = gi % CHANNELS;

            logic [TAPS-1:0]         tap_p;
            logic [TAPS-1:0]         tap_m;
            logic signed [CNT_W-1:0] delta;
            logic signed [CNT_W-1:0] cnt_reg;

            for (genvar gk = 0; gk < TAPS; gk++) begin : g_tap
                localparam int KR  = gk / KERNEL_W;
                localparam int KC  = gk % KERNEL_W;
                localparam int NY  = Y + PAD_H - KR;
                localparam int NX  = X + PAD_W - KC;
                localparam int BIT = C * TAPS + gk;
                localparam bit REACH = (NY >= 0) && (NY % STRIDE_H == 0) &&
                                       (NY / STRIDE_H < OUT_H) &&
                                       (NX >= 0) && (NX % STRIDE_W == 0) &&
                                       (NX / STRIDE_W < OUT_W);
                if (REACH) begin : g_hit
                    logic here;
                    assign here = (oy_reg == OY_W'(NY / STRIDE_H)) &&
                                  (ox_reg == OX_W'(NX / STRIDE_W));
                    assign tap_p[gk] = here && col_p[BIT] && !col_m[BIT];
                    assign tap_m[gk] = here && !col_p[BIT] && col_m[BIT];
                end else begin : g_miss
                    assign tap_p[gk] = 1'b0;
                    assign tap_m[gk] = 1'b0;
                end
            end

            assign delta = CNT_W'($countones(tap_p)) - CNT_W'($countones(tap_m));

            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    cnt_reg <= '0;
                end else if (release_frame) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    cnt_reg <= cnt_reg + delta;
                end
            end

            assign im_cnt[Y][X][C] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_stoch_signed_col2im.sv
// Directed bench for stoch_signed_col2im: a spec-level frame model checked
// every cycle, plus hand-computed pixel values for the default geometry.
module tb_stoch_signed_col2im;

    localparam int H = 4, W = 4, CH = 2, KH = 3, KW = 3, PH = 1, PW = 1, SH = 1, SW = 1;
    localparam int OH = (H + 2*PH - KH) / SH + 1;
    localparam int OW = (W + 2*PW - KW) / SW + 1;
    localparam int ROWS = OH * OW;
    localparam int COLW = KH * KW * CH;
    localparam int CW = 5;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [COLW-1:0] col_p = '0;
    logic [COLW-1:0] col_m = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [H-1:0][W-1:0][CH-1:0][CW-1:0] im_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: plain integers, updated from the spec's mapping rules.
    int mcnt [H][W][CH];
    int mrow = 0;
    bit mhold = 1'b0;

    stoch_signed_col2im dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .col_p(col_p), .col_m(col_m), .out_valid(out_valid),
        .out_ready(out_ready), .im_cnt(im_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pix(input int y, input int x, input int c);
        logic signed [CW-1:0] v;
        v = im_cnt[y][x][c];
        return int'(v);
    endfunction

    task automatic model_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int c = 0; c < CH; c++) mcnt[y][x][c] = 0;
        mrow = 0;
        mhold = 1'b0;
    endtask

    always @(posedge CLK) begin
        if (!nRST) begin
            model_clear();
        end else if (mhold) begin
            if (out_ready) model_clear();
        end else if (in_valid) begin
            for (int k = 0; k < COLW; k++) begin
                int kc, kr, c, y, x;
                kc = k % KW;
                kr = (k / KW) % KH;
                c  = k / (KH * KW);
                y  = (mrow / OW) * SH - PH + kr;
                x  = (mrow % OW) * SW - PW + kc;
                if (y >= 0 && y < H && x >= 0 && x < W) begin
                    if (col_p[k] && !col_m[k]) mcnt[y][x][c] += 1;
                    if (!col_p[k] && col_m[k]) mcnt[y][x][c] -= 1;
                end
            end
            mrow++;
            if (mrow == ROWS) mhold = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            int bad, by, bx, bc;
            bad = 0; by = 0; bx = 0; bc = 0;
            chk("cyc_in_ready", int'(in_ready), int'(!mhold));
            chk("cyc_out_valid", int'(out_valid), int'(mhold));
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    for (int c = 0; c < CH; c++)
                        if (bad == 0 && pix(y, x, c) != mcnt[y][x][c]) begin
                            bad = 1; by = y; bx = x; bc = c;
                        end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL cyc_im_cnt[%0d][%0d][%0d]: got %0d, expected %0d",
                         by, bx, bc, pix(by, bx, bc), mcnt[by][bx][bc]);
            end
        end
    end

    // Inputs change 1 time unit after a rising edge and are sampled on the next.
    task automatic step(input logic v, input logic [COLW-1:0] p, input logic [COLW-1:0] m,
                        input logic ordy, input logic rstn);
        @(posedge CLK);
        #1;
        in_valid = v; col_p = p; col_m = m; out_ready = ordy; nRST = rstn;
    endtask

    task automatic frame(input logic [COLW-1:0] p, input logic [COLW-1:0] m);
        for (int r = 0; r < ROWS; r++) step(1'b1, p, m, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic handshake();
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic check_ones(input string tag, input int s);
        for (int c = 0; c < CH; c++) begin
            chk({tag, "_11"}, pix(1, 1, c), 9 * s);
            chk({tag, "_00"}, pix(0, 0, c), 4 * s);
            chk({tag, "_01"}, pix(0, 1, c), 6 * s);
            chk({tag, "_33"}, pix(3, 3, c), 4 * s);
        end
    endtask

    logic [COLW-1:0] ones;
    logic [H-1:0][W-1:0][CH-1:0][CW-1:0] snap;
    int nz;

    initial begin
        ones = '1;

        // Reset for two cycles
        step(1'b0, '0, '0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_im_cnt_zero", int'(im_cnt == '0), 1);
        $display("reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);

        // All-ones positive rail; check latency around the last beat
        for (int r = 0; r < ROWS; r++) step(1'b1, ones, '0, 1'b0, 1'b1);
        chk("lat_before", int'(out_valid), 0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("lat_after", int'(out_valid), 1);
        check_ones("pos", 1);
        $display("frame p=ones: [1][1][0]=%0d [0][0][0]=%0d", pix(1, 1, 0), pix(0, 0, 0));
        handshake();
        chk("hs_cleared", int'(im_cnt == '0), 1);

        // p and m both set cancel out
        frame(ones, ones);
        chk("cancel_valid", int'(out_valid), 1);
        chk("cancel_zero", int'(im_cnt == '0), 1);
        $display("frame p=m=ones: all zero=%0d", im_cnt == '0);
        handshake();

        // Negative rail only
        frame('0, ones);
        for (int c = 0; c < CH; c++) begin
            chk("neg_00", pix(0, 0, c), -4);
            chk("neg_00_bits", int'(im_cnt[0][0][c]), int'(5'b11100));
            chk("neg_22", pix(2, 2, c), -9);
        end
        $display("frame m=ones: [0][0][0]=%0d [2][2][0]=%0d", pix(0, 0, 0), pix(2, 2, 0));
        handshake();

        // Held frame ignores in_valid while out_ready stays low
        frame(ones, '0);
        snap = im_cnt;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ones, '0, 1'b0, 1'b1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_stable", int'(im_cnt == snap), 1);
        end
        $display("hold: out_valid=%0d stable=%0d", out_valid, im_cnt == snap);
        step(1'b1, ones, '0, 1'b1, 1'b1);
        step(1'b1, COLW'(18'h10), '0, 1'b0, 1'b1);
        for (int r = 1; r < ROWS; r++) step(1'b1, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("single_valid", int'(out_valid), 1);
        chk("single_000", pix(0, 0, 0), 1);
        nz = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int c = 0; c < CH; c++)
                    if (!(y == 0 && x == 0 && c == 0) && pix(y, x, c) != 0) nz++;
        chk("single_others_zero", nz, 0);
        $display("single bit: [0][0][0]=%0d nonzero_others=%0d", pix(0, 0, 0), nz);
        handshake();

        // Partial frame discarded by reset, then a gappy full frame
        for (int r = 0; r < 7; r++) step(1'b1, ones, ones ^ ones, 1'b0, 1'b1);
        step(1'b1, ones, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("midrst_zero", int'(im_cnt == '0), 1);
        for (int r = 0; r < ROWS; r++) begin
            step(1'b1, ones, '0, 1'b0, 1'b1);
            step(1'b0, ones, ones, 1'b0, 1'b1);
        end
        chk("gap_valid", int'(out_valid), 1);
        check_ones("gap", 1);
        $display("gappy frame after reset: [1][1][1]=%0d [3][3][1]=%0d", pix(1, 1, 1), pix(3, 3, 1));
        handshake();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
